// File: rtl/i2c_eeprom_slave.sv
// I2C responder emulating a 24LC32A-style serial EEPROM on an internal byte array.
// Latency: pad changes seen ~3 clk later; SDA drive updates the cycle after a detected SCL fall.
// Backpressure: none; SCL is never stretched, non-matching control bytes are NAK'd.
module i2c_eeprom_slave #(
  parameter logic [6:0] SLV_ADDR   = 7'd1,
  parameter int         MEM_AWIDTH = 12,
  parameter int         PAGE_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_SCL_i,
  input  logic                  i2c_SDA_i,
  output logic                  i2c_SDA_o,
  output logic                  i2c_SDA_e,
  output logic                  busy,
  output logic                  wr_pulse,
  output logic [MEM_AWIDTH-1:0] cur_addr
);

  localparam int MEM_DEPTH = 1 << MEM_AWIDTH;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CTRL    = 3'd1;
  localparam logic [2:0] S_ADDR_HI = 3'd2;
  localparam logic [2:0] S_ADDR_LO = 3'd3;
  localparam logic [2:0] S_WR_BYTE = 3'd4;
  localparam logic [2:0] S_RD_BYTE = 3'd5;

  // [0] first sync stage, [1] synchronized sample, [2] history sample
  logic [2:0] scl_sync;
  logic [2:0] sda_sync;
  logic       scl_now, scl_old, sda_now, sda_old;
  logic       scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]            state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shreg;      // receive shifter
  logic [7:0]            rd_sh;      // transmit shifter, MSB is the bit on the wire
  logic                  byte_full;  // 8 bits received, waiting for the 8th fall
  logic                  ack_slot;   // our ACK slot (receive) or pre-load slot before a read byte
  logic                  mack_slot;  // master's ACK/NAK bit after a read byte
  logic [MEM_AWIDTH-1:0] addr;
  logic [MEM_AWIDTH-1:0] addr_seq;
  logic [MEM_AWIDTH-1:0] addr_page;
  logic                  mem_we;

  logic [7:0] mem [MEM_DEPTH];

  assign i2c_SDA_o = 1'b0;
  assign cur_addr  = addr;

  assign scl_now = scl_sync[1];
  assign scl_old = scl_sync[2];
  assign sda_now = sda_sync[1];
  assign sda_old = sda_sync[2];

  assign scl_rise  = scl_now & ~scl_old;
  assign scl_fall  = ~scl_now & scl_old;
  assign start_det = scl_now & scl_old & sda_old & ~sda_now;
  assign stop_det  = scl_now & scl_old & ~sda_old & sda_now;

  // Sequential reads wrap over the whole array; writes wrap inside the page.
  assign addr_seq  = addr + MEM_AWIDTH'(1);
  assign addr_page = {addr[MEM_AWIDTH-1:PAGE_BITS], addr[PAGE_BITS-1:0] + PAGE_BITS'(1)};

  // A data byte lands in the array on its 8th SCL fall, unless a bus condition wins.
  assign mem_we = ~rst & ~start_det & ~stop_det & (state == S_WR_BYTE) &
                  byte_full & ~ack_slot & scl_fall;

  // Pad synchronizers; reset to the idle-bus level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], i2c_SCL_i};
      sda_sync <= {sda_sync[1:0], i2c_SDA_i};
    end
  end

  // Backing array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= shreg;
    end
  end

  // Protocol FSM: bus conditions first, then per-state bit handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rd_sh     <= '0;
      byte_full <= 1'b0;
      ack_slot  <= 1'b0;
      mack_slot <= 1'b0;
      addr      <= '0;
      i2c_SDA_e <= 1'b0;
      busy      <= 1'b0;
      wr_pulse  <= 1'b0;
    end else begin
      wr_pulse <= mem_we;
      if (start_det) begin
        state     <= S_CTRL;
        bit_cnt   <= '0;
        byte_full <= 1'b0;
        ack_slot  <= 1'b0;
        mack_slot <= 1'b0;
        i2c_SDA_e <= 1'b0;
      end else if (stop_det) begin
        state     <= S_IDLE;
        bit_cnt   <= '0;
        byte_full <= 1'b0;
        ack_slot  <= 1'b0;
        mack_slot <= 1'b0;
        i2c_SDA_e <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            i2c_SDA_e <= 1'b0;
          end
          S_RD_BYTE: begin
            if (ack_slot) begin
              // Slot ends: put the MSB of the loaded byte on the wire.
              if (scl_fall) begin
                ack_slot  <= 1'b0;
                bit_cnt   <= '0;
                i2c_SDA_e <= ~rd_sh[7];
              end
            end else if (mack_slot) begin
              if (scl_rise) begin
                mack_slot <= 1'b0;
                if (!sda_now) begin
                  addr     <= addr_seq;
                  rd_sh    <= mem[addr_seq];
                  ack_slot <= 1'b1;
                end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end
              end
            end else if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                i2c_SDA_e <= 1'b0;
                mack_slot <= 1'b1;
              end else begin
                i2c_SDA_e <= ~rd_sh[6];
                rd_sh     <= {rd_sh[6:0], 1'b0};
                bit_cnt   <= bit_cnt + 3'd1;
              end
            end
          end
          default: begin
            // Receive states: CTRL, ADDR_HI, ADDR_LO, WR_BYTE.
            if (ack_slot) begin
              if (scl_fall) begin
                ack_slot  <= 1'b0;
                i2c_SDA_e <= 1'b0;
              end
            end else if (byte_full) begin
              if (scl_fall) begin
                byte_full <= 1'b0;
                case (state)
                  S_CTRL: begin
                    if (shreg[7:1] == SLV_ADDR) begin
                      busy      <= 1'b1;
                      i2c_SDA_e <= 1'b1;
                      ack_slot  <= 1'b1;
                      if (shreg[0]) begin
                        state <= S_RD_BYTE;
                        rd_sh <= mem[addr];
                      end else begin
                        state <= S_ADDR_HI;
                      end
                    end else begin
                      state     <= S_IDLE;
                      i2c_SDA_e <= 1'b0;
                      busy      <= 1'b0;
                    end
                  end
                  S_ADDR_HI: begin
                    addr[MEM_AWIDTH-1:8] <= shreg[MEM_AWIDTH-9:0];
                    i2c_SDA_e <= 1'b1;
                    ack_slot  <= 1'b1;
                    state     <= S_ADDR_LO;
                  end
                  S_ADDR_LO: begin
                    addr[7:0] <= shreg;
                    i2c_SDA_e <= 1'b1;
                    ack_slot  <= 1'b1;
                    state     <= S_WR_BYTE;
                  end
                  default: begin
                    // WR_BYTE: array write happens via mem_we this same cycle.
                    addr      <= addr_page;
                    i2c_SDA_e <= 1'b1;
                    ack_slot  <= 1'b1;
                  end
                endcase
              end
            end else if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_now};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_full <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master, write table, scoreboard readback.
// Latency: one SCL quarter period is Q system clocks.
// Backpressure: none; the master owns SCL throughout.
module tb_i2c_eeprom_slave;

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_o, sda_e, busy, wr_pulse;
  logic [11:0] cur_addr;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;

  logic [7:0] model [4096];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [11:0] addr;
    int          n;
    logic [31:0] data;     // first byte in [31:24]
    logic [11:0] exp_end;
  } wvec_t;

  wvec_t wv [4];

  assign sda_bus = sda_m & ~sda_e;

  i2c_eeprom_slave #(.SLV_ADDR(7'd1), .MEM_AWIDTH(12), .PAGE_BITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .i2c_SCL_i (scl),
    .i2c_SDA_i (sda_bus),
    .i2c_SDA_o (sda_o),
    .i2c_SDA_e (sda_e),
    .busy      (busy),
    .wr_pulse  (wr_pulse),
    .cur_addr  (cur_addr)
  );

  always #5 clk = ~clk;

  // Activity monitors
  always @(posedge clk) begin
    if (wr_pulse) wr_cnt <= wr_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b; tick(Q);
    scl = 1'b1; tick(Q);
    s = sda_bus; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nak, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(nak, s);
  endtask

  task automatic read_and_score(input logic nak, input string name);
    logic [7:0] d;
    logic [7:0] e;
    recv_byte(nak, d);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got 0x%0h, expected nothing (scoreboard empty)", name, d);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'h0, d}, {24'h0, e});
    end
  endtask

  // START, control(W), 2 address bytes; returns number of ACKs seen.
  task automatic set_addr(input logic [11:0] a, output int acks);
    logic ack;
    acks = 0;
    i2c_start();
    send_byte(8'h02, ack); acks += int'(ack);
    send_byte({4'h0, a[11:8]}, ack); acks += int'(ack);
    send_byte(a[7:0], ack); acks += int'(ack);
  endtask

  task automatic do_write(input wvec_t v);
    int         acks;
    int         wr0;
    logic       ack;
    logic [4:0] off;
    wr0 = wr_cnt;
    set_addr(v.addr, acks);
    check("busy_after_ctrl", {31'h0, busy}, 32'd1);
    for (int i = 0; i < v.n; i++) begin
      send_byte(v.data[31-8*i -: 8], ack);
      acks += int'(ack);
      off = v.addr[4:0] + 5'(i);
      model[{v.addr[11:5], off}] = v.data[31-8*i -: 8];
    end
    i2c_stop();
    tick(4);
    check("write_acks", acks, v.n + 3);
    check("wr_pulse_count", wr_cnt - wr0, v.n);
    check("cur_addr_after_write", {20'h0, cur_addr}, {20'h0, v.exp_end});
    check("busy_after_stop", {31'h0, busy}, 32'd0);
  endtask

  // Random read of n bytes with master ACK on all but the last.
  task automatic seq_read(input logic [11:0] a, input int n, input string name);
    int   acks;
    logic ack;
    logic [11:0] ra;
    set_addr(a, acks);
    i2c_start();
    send_byte(8'h03, ack); acks += int'(ack);
    check("read_setup_acks", acks, 4);
    for (int i = 0; i < n; i++) begin
      ra = a + 12'(i);
      exp_q.push_back(model[ra]);
      read_and_score(i == n - 1, name);
    end
    tick(2);
    check("busy_after_nak", {31'h0, busy}, 32'd0);
    check("sda_released_after_nak", {31'h0, sda_e}, 32'd0);
    i2c_stop();
    tick(2);
  endtask

  initial begin
    int   acks;
    int   wr0;
    int   b0;
    logic ack, a2, a3, s;
    logic [4:0] off;

    wv[0] = '{addr: 12'h123, n: 4, data: 32'hDEADBEEF, exp_end: 12'h127};
    wv[1] = '{addr: 12'h01E, n: 4, data: 32'h11223344, exp_end: 12'h002};
    wv[2] = '{addr: 12'hFFF, n: 3, data: 32'hA1B2C300, exp_end: 12'hFE2};
    wv[3] = '{addr: 12'h7C0, n: 1, data: 32'h5A000000, exp_end: 12'h7C1};

    // Reset state
    tick(4);
    check("rst_sda_e", {31'h0, sda_e}, 32'd0);
    check("rst_sda_o", {31'h0, sda_o}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_wr_pulse", {31'h0, wr_pulse}, 32'd0);
    check("rst_cur_addr", {20'h0, cur_addr}, 32'd0);
    rst = 1'b0;
    tick(4);

    // Table of page writes
    for (int r = 0; r < 4; r++) do_write(wv[r]);

    // Read every written byte back through single-byte random reads
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < wv[r].n; i++) begin
        off = wv[r].addr[4:0] + 5'(i);
        seq_read({wv[r].addr[11:5], off}, 1, "readback");
      end
    end

    // Random read with ACK, ACK, ACK, NAK
    seq_read(12'h123, 4, "random_read");
    check("cur_addr_after_read", {20'h0, cur_addr}, 32'h126);

    // Sequential read wrapping across the top of the array
    seq_read(12'hFFF, 3, "read_wrap");
    check("cur_addr_after_wrap", {20'h0, cur_addr}, 32'h001);

    // Address mismatch: NAK and ignore following bytes
    wr0 = wr_cnt;
    b0 = busy_cnt;
    i2c_start();
    send_byte(8'h0A, ack);
    check("mismatch_nak", {31'h0, ack}, 32'd0);
    send_byte(8'h01, a2);
    send_byte(8'h23, a3);
    check("mismatch_follow_acks", {31'h0, a2 | a3}, 32'd0);
    i2c_stop();
    tick(4);
    check("mismatch_no_write", wr_cnt - wr0, 0);
    check("mismatch_busy_never", busy_cnt - b0, 0);

    // STOP after 4 bits of a data byte
    wr0 = wr_cnt;
    set_addr(12'h500, acks);
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
    i2c_stop();
    tick(4);
    check("abort_no_write", wr_cnt - wr0, 0);
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_cur_addr", {20'h0, cur_addr}, 32'h500);

    // Reset while the slave drives a 0 read bit (0xDE: bits 1,1,0)
    set_addr(12'h123, acks);
    i2c_start();
    send_byte(8'h03, ack);
    send_bit(1'b1, s);
    send_bit(1'b1, s);
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    check("rd_drives_zero", {31'h0, sda_e}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_releases_sda", {31'h0, sda_e}, 32'd0);
    rst = 1'b0;
    tick(Q);
    scl = 1'b0;
    tick(Q);
    check("rst_mid_cur_addr", {20'h0, cur_addr}, 32'd0);

    // Full transaction after the mid-transfer reset
    do_write('{addr: 12'h300, n: 2, data: 32'h66770000, exp_end: 12'h302});
    seq_read(12'h300, 2, "post_reset_read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
